// File: rtl/lcd_pkg.sv
// Shared constants for the LCD pixel-clock generator: panel IDs, their divide
// ratios, default widths and the generator FSM state type.
package lcd_pkg;

   localparam int ID_W_DEF  = 16;
   localparam int DIV_W_DEF = 8;

   localparam logic [15:0] PANEL_4342 = 16'h4342;
   localparam logic [15:0] PANEL_7084 = 16'h7084;
   localparam logic [15:0] PANEL_7016 = 16'h7016;
   localparam logic [15:0] PANEL_4384 = 16'h4384;
   localparam logic [15:0] PANEL_1018 = 16'h1018;

   localparam int DIV_4342 = 8;
   localparam int DIV_7084 = 4;
   localparam int DIV_7016 = 2;
   localparam int DIV_4384 = 4;
   localparam int DIV_1018 = 2;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_LOAD  = 2'd3
   } pclk_state_e;

endpackage

// File: rtl/lcd_id_lut.sv
// Panel-ID to pixel-clock divide-ratio table; unknown panels map to 0 (stopped).
module lcd_id_lut
   import lcd_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic [ID_W-1:0]  lcd_id,
   output logic [DIV_W-1:0] ratio
);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      ratio = '0;
      case (lcd_id)
         ID_W'(PANEL_4342): ratio = DIV_W'(DIV_4342);
         ID_W'(PANEL_7084): ratio = DIV_W'(DIV_7084);
         ID_W'(PANEL_7016): ratio = DIV_W'(DIV_7016);
         ID_W'(PANEL_4384): ratio = DIV_W'(DIV_4384);
         ID_W'(PANEL_1018): ratio = DIV_W'(DIV_1018);
         default:           ratio = '0;
      endcase
   end

endmodule

// File: rtl/lcd_pclk_gen.sv
// LCD pixel-clock generator: divides clk by a panel-dependent even ratio and
// switches ratios glitch-free. Define LCD_PCLK_OVR_EN to add ovr_en/ovr_div.
module lcd_pclk_gen
   import lcd_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ID_W-1:0]  lcd_id,
`ifdef LCD_PCLK_OVR_EN
   input  logic             ovr_en,
   input  logic [DIV_W-1:0] ovr_div,
`endif
   output logic             lcd_pclk,
   output logic             pclk_rise,
   output logic             pclk_fall,
   output logic             locked,
   output logic [DIV_W-1:0] cur_div
);

   logic [DIV_W-1:0] lut_ratio;
   logic [DIV_W-1:0] sel_ratio;
   logic [DIV_W-1:0] ratio;
   logic [DIV_W-1:0] half;
   logic [DIV_W-1:0] cnt, cnt_nxt, div_nxt;
   logic             pclk_nxt;
   logic             tick;
   pclk_state_e      state, state_nxt;

   lcd_id_lut #(.ID_W(ID_W), .DIV_W(DIV_W)) u_lut (
      .lcd_id (lcd_id),
      .ratio  (lut_ratio)
   );

`ifdef LCD_PCLK_OVR_EN
   assign sel_ratio = ovr_en ? ovr_div : lut_ratio;
`else
   assign sel_ratio = lut_ratio;
`endif

   // Odd ratios cannot give 50% duty, so the LSB is dropped.
   assign ratio = {sel_ratio[DIV_W-1:1], 1'b0};
   assign half  = cur_div >> 1;
   assign tick  = (cnt == half - DIV_W'(1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pclk_nxt  = lcd_pclk;
      div_nxt   = cur_div;
      case (state)
         ST_STOP: begin
            cnt_nxt  = '0;
            pclk_nxt = 1'b0;
            div_nxt  = '0;
            if (ratio != '0) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_nxt   = '0;
            pclk_nxt  = 1'b0;
            div_nxt   = ratio;
            state_nxt = (ratio == '0) ? ST_STOP : ST_RUN;
         end
         ST_RUN, ST_DRAIN: begin
            // Drain exits only from a low phase, so a high phase is never cut short.
            if (state == ST_DRAIN && !lcd_pclk) begin
               state_nxt = ST_LOAD;
            end else begin
               if (tick) begin
                  cnt_nxt  = '0;
                  pclk_nxt = ~lcd_pclk;
               end else begin
                  cnt_nxt = cnt + DIV_W'(1);
               end
               if (state == ST_RUN && ratio != cur_div) state_nxt = ST_DRAIN;
            end
         end
         default: state_nxt = ST_STOP;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_STOP;
         cnt       <= '0;
         cur_div   <= '0;
         lcd_pclk  <= 1'b0;
         pclk_rise <= 1'b0;
         pclk_fall <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cur_div   <= div_nxt;
         lcd_pclk  <= pclk_nxt;
         pclk_rise <= pclk_nxt & ~lcd_pclk;
         pclk_fall <= ~pclk_nxt & lcd_pclk;
         locked    <= (state_nxt == ST_RUN);
      end
   end

endmodule

// File: tb/tb_lcd_pclk_gen.sv
// Self-checking bench for lcd_pclk_gen: directed scenarios plus random panel-ID
// changes, compared every cycle against a countdown-based behavioural model.
module tb_lcd_pclk_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] lcd_id = 16'h0000;
   logic        lcd_pclk, pclk_rise, pclk_fall, locked;
   logic [7:0]  cur_div;
`ifdef LCD_PCLK_OVR_EN
   logic        ovr_en  = 1'b0;
   logic [7:0]  ovr_div = 8'h00;
`endif

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   lcd_pclk_gen #(.ID_W(16), .DIV_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .lcd_id    (lcd_id),
`ifdef LCD_PCLK_OVR_EN
      .ovr_en    (ovr_en),
      .ovr_div   (ovr_div),
`endif
      .lcd_pclk  (lcd_pclk),
      .pclk_rise (pclk_rise),
      .pclk_fall (pclk_fall),
      .locked    (locked),
      .cur_div   (cur_div)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [15:0] tbl_id  [5] = '{16'h4342, 16'h7084, 16'h7016, 16'h4384, 16'h1018};
   int          tbl_div [5] = '{8, 4, 2, 4, 2};

   typedef enum {M_IDLE, M_GEN, M_FINISH, M_RELOAD} model_mode_e;
   model_mode_e m_mode   = M_IDLE;
   int          m_div    = 0;
   int          m_left   = 0;
   bit          m_pclk   = 0;
   bit          m_rise   = 0;
   bit          m_fall   = 0;
   bit          m_locked = 0;

   function automatic int model_ratio();
      int r = 0;
      for (int i = 0; i < 5; i++) if (lcd_id == tbl_id[i]) r = tbl_div[i];
`ifdef LCD_PCLK_OVR_EN
      if (ovr_en) r = int'(ovr_div);
`endif
      return r - (r % 2);
   endfunction

   task automatic model_advance();
      m_left = m_left - 1;
      if (m_left == 0) begin
         m_pclk = !m_pclk;
         m_left = m_div / 2;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = M_IDLE; m_div = 0; m_left = 0;
         m_pclk = 0; m_rise = 0; m_fall = 0; m_locked = 0;
      end else begin
         int r;
         bit prev;
         r    = model_ratio();
         prev = m_pclk;
         case (m_mode)
            M_IDLE:   if (r != 0) m_mode = M_RELOAD;
            M_RELOAD: begin
               m_div  = r;
               m_left = r / 2;
               m_mode = (r == 0) ? M_IDLE : M_GEN;
            end
            M_GEN: begin
               if (r != m_div) m_mode = M_FINISH;
               model_advance();
            end
            M_FINISH: if (!m_pclk) m_mode = M_RELOAD; else model_advance();
         endcase
         m_rise   = !prev && m_pclk;
         m_fall   = prev && !m_pclk;
         m_locked = (m_mode == M_GEN);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("mdl_pclk",    lcd_pclk,  m_pclk);
         check("mdl_rise",    pclk_rise, m_rise);
         check("mdl_fall",    pclk_fall, m_fall);
         check("mdl_locked",  locked,    m_locked);
         check("mdl_cur_div", cur_div,   m_div);
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_rise(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pclk_rise && n <= limit);
   endtask

   task automatic measure_period(output int p);
      int n;
      wait_rise(64, n);
      wait_rise(64, p);
   endtask

   task automatic wait_pclk_high();
      for (int i = 0; i < 64 && !lcd_pclk; i++) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, p, low;
      bit saw8;

      #1 rst = 1'b1;
      lcd_id = 16'h7084;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_pclk",    lcd_pclk,  1'b0);
      check("rst_rise",    pclk_rise, 1'b0);
      check("rst_fall",    pclk_fall, 1'b0);
      check("rst_locked",  locked,    1'b0);
      check("rst_cur_div", cur_div,   8'd0);

      // Release reset with a known panel: first rise at N/2+2 edges.
      rst = 1'b0;
      wait_rise(20, n);
      check("first_rise_7084", n, 4);
      check("cur_div_7084", cur_div, 8'd4);
      check("locked_7084", locked, 1'b1);
      measure_period(p);
      check("period_7084", p, 4);

      // Switch 7016 -> 4342 while lcd_pclk is high.
      lcd_id = 16'h7016;
      repeat (12) @(negedge clk);
      measure_period(p);
      check("period_7016", p, 2);
      @(negedge clk);
      wait_pclk_high();
      lcd_id = 16'h4342;
      @(negedge clk);
      check("high_kept_full", lcd_pclk, 1'b0);
      low = 1;
      while (!lcd_pclk && low < 40) begin
         @(negedge clk);
         if (!lcd_pclk) low++;
      end
      check("low_after_switch", low, 6);
      measure_period(p);
      check("period_4342", p, 8);
      check("cur_div_4342", cur_div, 8'd8);

      // Unknown panel stops the clock; a known one restarts it quickly.
      lcd_id = 16'hFFFF;
      repeat (24) @(negedge clk);
      check("stop_pclk", lcd_pclk, 1'b0);
      check("stop_locked", locked, 1'b0);
      check("stop_cur_div", cur_div, 8'd0);
      lcd_id = 16'h1018;
      wait_rise(10, n);
      check("stop_to_run_rise", n, 3);
      measure_period(p);
      check("period_1018", p, 2);

      // Two ID changes inside one drain: one reload with the latest ratio.
      lcd_id = 16'h7084;
      repeat (12) @(negedge clk);
      wait_rise(20, n);
      lcd_id = 16'h4342;
      @(negedge clk);
      lcd_id = 16'h7016;
      low  = 1;
      saw8 = 1'b0;
      while (!locked && low < 20) begin
         @(negedge clk);
         if (cur_div == 8'd8) saw8 = 1'b1;
         if (!locked) low++;
      end
      check("drain_unlocked_cycles", low, 3);
      check("no_extra_load", saw8, 1'b0);
      check("cur_div_latest", cur_div, 8'd2);

      // Reset pulsed mid-period while lcd_pclk is high at ratio 8.
      lcd_id = 16'h4342;
      repeat (24) @(negedge clk);
      wait_rise(20, n);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pclk",    lcd_pclk, 1'b0);
      check("async_rst_locked",  locked,   1'b0);
      check("async_rst_cur_div", cur_div,  8'd0);
      check("async_rst_rise",    pclk_rise, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      wait_rise(20, n);
      check("first_rise_4342", n, 6);

`ifdef LCD_PCLK_OVR_EN
      ovr_div = 8'd7;
      ovr_en  = 1'b1;
      repeat (20) @(negedge clk);
      check("ovr_cur_div", cur_div, 8'd6);
      measure_period(p);
      check("ovr_period", p, 6);
      ovr_en = 1'b0;
`endif

      // Random panel changes and reset pulses, checked by the model.
      for (int it = 0; it < 120; it++) begin
         int k;
         k = int'($urandom_range(0, 8));
         if (k < 5) lcd_id = tbl_id[k];
         else if (k == 5) lcd_id = 16'hFFFF;
         else if (k == 6) lcd_id = 16'($urandom);
         else if (k == 7) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
`ifdef LCD_PCLK_OVR_EN
         else begin
            ovr_en  = ~ovr_en;
            ovr_div = 8'($urandom_range(0, 20));
         end
`endif
         repeat ($urandom_range(1, 30)) @(negedge clk);
      end

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_pclk_gen.md
LCD_PCLK_GEN -- requirements
Module: lcd_pclk_gen

Interface
REQ-001 The parameter ID_W SHALL default to 16 and set the panel ID width.
REQ-002 The parameter DIV_W SHALL default to 8 and set the divide-ratio width.
REQ-003 The port clk SHALL be an input, 1 bit wide, and carry the single 50 MHz system clock.
REQ-004 The port rst SHALL be an input, 1 bit wide, and act as an asynchronous, active-high reset.
REQ-005 The port lcd_id SHALL be an input, ID_W bits wide, and carry the panel identifier, sampled every clk cycle.
REQ-006 The port lcd_pclk SHALL be an output, 1 bit wide, driven from a register as the pixel clock.
REQ-007 The port pclk_rise SHALL be an output, 1 bit wide, pulsing for one clk cycle on the cycle lcd_pclk goes 0->1.
REQ-008 The port pclk_fall SHALL be an output, 1 bit wide, pulsing for one clk cycle on the cycle lcd_pclk goes 1->0.
REQ-009 The port locked SHALL be an output, 1 bit wide, high only while the generator runs at a stable ratio.
REQ-010 The port cur_div SHALL be an output, DIV_W bits wide, giving the active divide ratio (0 = stopped).

Function
REQ-011 The ratio lookup SHALL map 4342->8, 7084->4, 7016->2, 4384->4, 1018->2 and any other ID->0.
REQ-012 The generator SHALL force the lookup LSB to 0; a resulting 0 means STOP.
REQ-013 The FSM SHALL have four states: STOP, RUN, DRAIN, LOAD.
REQ-014 In RUN with ratio N, a half-period counter SHALL count 0..N/2-1, toggle lcd_pclk at N/2-1 and wrap to 0, so lcd_pclk has period N clk cycles and 50% duty.
REQ-015 In STOP, lcd_pclk SHALL be held at 0, the counter at 0, and cur_div at 0.
REQ-016 STOP SHALL go to LOAD when the lookup returns a nonzero ratio.
REQ-017 RUN SHALL go to DRAIN when the lookup differs from cur_div; RUN SHALL stay in RUN otherwise.
REQ-018 DRAIN SHALL let the current half period finish normally and leave only on the cycle lcd_pclk is 0, going to LOAD.
REQ-019 A high phase SHALL therefore never be truncated.
REQ-020 LOAD SHALL last one clk cycle, latch the current lookup into cur_div, and clear the counter.
REQ-021 LOAD SHALL go to STOP if the latched value is 0, otherwise to RUN.
REQ-022 The first high phase after LOAD SHALL begin N/2 cycles after entering RUN, so the low phase is at least one new half period.
REQ-023 If lcd_id changes again during DRAIN, the value latched in LOAD SHALL be the latest lookup; there SHALL be no extra drain.
REQ-024 If lcd_id returns to the cur_div mapping during DRAIN, the FSM SHALL still pass through LOAD, reloading the same ratio.
REQ-025 locked SHALL equal (state==RUN), registered.
REQ-026 pclk_rise and pclk_fall SHALL be registered alongside lcd_pclk and be mutually exclusive.

Reset
REQ-027 While rst is high, state SHALL be STOP and lcd_pclk, pclk_rise, pclk_fall, locked, cur_div and the counter SHALL all be 0.
REQ-028 Reset asserted mid-period SHALL force lcd_pclk low immediately.
REQ-029 After rst deasserts, the generator SHALL start from STOP via REQ-016 (first rise at N/2+2 cycles).

Configuration
REQ-030 With LCD_PCLK_OVR_EN defined, the ports ovr_en (in, 1) and ovr_div (in, DIV_W) SHALL exist.
REQ-031 With LCD_PCLK_OVR_EN defined, ovr_en=1 SHALL substitute ovr_div (LSB forced 0) for the table lookup, with identical switching rules.
REQ-032 Without LCD_PCLK_OVR_EN, neither port SHALL exist and only the table SHALL be used.

Structure
REQ-033 The package lcd_pkg SHALL hold the panel-ID constants, the FSM state enum, and the default ID_W/DIV_W constants.
REQ-034 The ID-to-ratio table SHALL be one combinational sub-module, lcd_id_lut (lcd_id -> ratio), reused by the LCD timing generator.

Verification
REQ-035 Scenario: rst released with lcd_id=16'h7084 -> STOP->LOAD->RUN, lcd_pclk period 4 cycles, locked=1, cur_div=4.
REQ-036 Scenario: lcd_id 16'h7016->16'h4342 while lcd_pclk is high -> lcd_pclk stays high for its full 1 cycle, goes low, then stays low for at least 4 cycles, then runs at period 8; locked is low during DRAIN/LOAD.
REQ-037 Scenario: lcd_id=16'hFFFF -> lcd_pclk stays 0, locked=0, cur_div=0; then 16'h1018 -> period 2 within 4 cycles.
REQ-038 Scenario: lcd_id toggles 7084->4342->7016 within DRAIN -> a single LOAD with cur_div=2 and no high pulse shorter than 1 cycle.
REQ-039 Scenario: rst pulsed while running at ratio 8 with lcd_pclk high -> lcd_pclk=0 in the same cycle and all outputs 0.
REQ-040 Scenario: with LCD_PCLK_OVR_EN defined, ovr_en=1 and ovr_div=7 -> cur_div=6 and lcd_pclk period 6.
